// File: rtl/gcd_arbiter.sv
// Round-robin front end sharing one GCD core among N_REQ requesters, with a
// zero-operand bypass and a per-job timeout that aborts and resets the core.
module gcd_arbiter #(
  parameter int OP_SZ   = 8,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*OP_SZ-1:0] a_in,
  input  logic [N_REQ*OP_SZ-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [OP_SZ-1:0]       rsp_res,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic [OP_SZ-1:0]       core_A,
  output logic [OP_SZ-1:0]       core_B,
  output logic                   core_rst,
  input  logic [OP_SZ-1:0]       core_res,
  input  logic                   core_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, RESP} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, owner, win;
  logic             win_found, win_skip;
  logic [OP_SZ-1:0] win_a, win_b;
  logic [OP_SZ-1:0] op_a, op_b, res_q;
  logic             skip, timed_out;
  logic [CNT_W-1:0] cnt;
  logic             cnt_expired;

  // Search from rr_ptr upward first, then wrap to the low indices.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i] && (PTR_W'(i) >= rr_ptr)) begin
        win       = PTR_W'(i);
        win_found = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!win_found && req[i]) begin
        win       = PTR_W'(i);
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_a = a_in[i*OP_SZ +: OP_SZ];
        win_b = b_in[i*OP_SZ +: OP_SZ];
      end
    end
  end

  assign win_skip    = (win_a == '0) || (win_b == '0);
  assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Zero-operand jobs pass through DRAIN so the bypass result is registered
  // the same way as a core result.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      skip      <= 1'b0;
      cnt       <= '0;
      res_q     <= '0;
      timed_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            owner     <= win;
            op_a      <= win_a;
            op_b      <= win_b;
            skip      <= win_skip;
            cnt       <= '0;
            res_q     <= '0;
            timed_out <= 1'b0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (!core_done && cnt_expired) begin
            timed_out <= 1'b1;
            res_q     <= '0;
          end
        end
        DRAIN: begin
          res_q <= skip ? (op_a | op_b) : core_res;
        end
        RESP: begin
          rr_ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    gnt        = '0;
    rsp_valid  = '0;
    rsp_res    = '0;
    rsp_err    = 1'b0;
    core_start = 1'b0;
    core_A     = '0;
    core_B     = '0;
    core_rst   = rst;
    case (state)
      IDLE: begin
        if (win_found) begin
          gnt[win]  = 1'b1;
          state_nxt = win_skip ? DRAIN : BUSY;
        end
      end
      BUSY: begin
        core_start = 1'b1;
        core_A     = op_a;
        core_B     = op_b;
        if (core_done) begin
          state_nxt = DRAIN;
        end else if (cnt_expired) begin
          state_nxt = RESP;
        end
      end
      DRAIN: begin
        state_nxt = RESP;
      end
      RESP: begin
        state_nxt        = IDLE;
        rsp_valid[owner] = 1'b1;
        rsp_res          = res_q;
        rsp_err          = timed_out;
        core_rst         = rst | timed_out;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset silences everything except the core reset.
    if (rst) begin
      gnt        = '0;
      rsp_valid  = '0;
      rsp_res    = '0;
      rsp_err    = 1'b0;
      core_start = 1'b0;
      core_A     = '0;
      core_B     = '0;
    end
  end

endmodule
